// File: rtl/sdram_client.sv
// sdram_client: host-side requester for the SDRAM controller chipset port.
// Issues power-up and refresh filler cycles and captures the 2-word read burst.
module sdram_client #(
  parameter int INIT_CYCLES = 85000,
  parameter int REF_IDLE    = 1024,
  parameter int CAP_FIRST   = 6,
  parameter int CAP_SECOND  = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_req,
  input  logic [24:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [24:0] rd_addr,
  output logic        rd_ack,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        ready,
  output logic [24:0] sdc_addr,
  output logic        sdc_we,
  output logic        sdc_rd,
  output logic [7:0]  sdc_di,
  input  logic [4:0]  sdc_cycle,
  input  logic [15:0] sd_data_in
);

  localparam int ICW = $clog2(INIT_CYCLES + 1);
  localparam int RCW = $clog2(REF_IDLE + 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_BUSY
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [ICW-1:0] r_init_cnt;
  logic [RCW-1:0] r_idle_cnt;
  logic           r_host_rd;

  logic w_free;
  logic w_go_init;
  logic w_go_wr;
  logic w_go_rd;
  logic w_go_ref;
  logic w_go;
  logic w_end;
  logic w_ref_due;
  logic w_unused_bits;

  assign w_unused_bits = ^rd_addr[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT, S_IDLE: if (w_go) w_next = S_BUSY;
      S_BUSY: begin
        if (w_end)
          w_next = (ready || r_init_cnt == ICW'(1)) ? S_IDLE : S_INIT;
      end
      default: w_next = S_INIT;
    endcase
  end

  // A slot opens only when the controller is parked at cycle 0 with no command.
  always_comb begin
    w_free    = (sdc_cycle == 5'd0) && !sdc_we && !sdc_rd;
    w_ref_due = (r_idle_cnt == RCW'(REF_IDLE - 1));
    w_go_init = (r_state == S_INIT) && w_free;
    w_go_wr   = (r_state == S_IDLE) && w_free && wr_req;
    w_go_rd   = (r_state == S_IDLE) && w_free && !wr_req && rd_req;
    w_go_ref  = (r_state == S_IDLE) && w_free && !wr_req && !rd_req
                && w_ref_due;
    w_go      = w_go_init || w_go_wr || w_go_rd || w_go_ref;
    w_end     = (r_state == S_BUSY) && (sdc_cycle == 5'd15);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      ready      <= 1'b0;
      sdc_addr   <= '0;
      sdc_we     <= 1'b0;
      sdc_rd     <= 1'b0;
      sdc_di     <= '0;
      r_host_rd  <= 1'b0;
      r_init_cnt <= ICW'(INIT_CYCLES);
      r_idle_cnt <= '0;
    end else begin
      wr_ack   <= w_go_wr;
      rd_ack   <= w_go_rd;
      rd_valid <= (r_state == S_BUSY) && r_host_rd
                  && (sdc_cycle == 5'(CAP_SECOND + 1));

      if (w_go)
        r_idle_cnt <= '0;
      else if (r_state == S_IDLE && !w_ref_due)
        r_idle_cnt <= r_idle_cnt + RCW'(1);

      if (w_go_init) begin
        sdc_rd    <= 1'b1;
        sdc_addr  <= '0;
        r_host_rd <= 1'b0;
      end
      if (w_go_wr) begin
        sdc_we    <= 1'b1;
        sdc_addr  <= wr_addr;
        sdc_di    <= wr_data;
        r_host_rd <= 1'b0;
      end
      if (w_go_rd) begin
        sdc_rd    <= 1'b1;
        sdc_addr  <= {rd_addr[24:2], 2'b00};
        r_host_rd <= 1'b1;
      end
      if (w_go_ref) begin
        sdc_rd    <= 1'b1;
        r_host_rd <= 1'b0;
      end

      if (r_state == S_BUSY && r_host_rd) begin
        if (sdc_cycle == 5'(CAP_FIRST))
          rd_data[15:0] <= sd_data_in;
        if (sdc_cycle == 5'(CAP_SECOND))
          rd_data[31:16] <= sd_data_in;
      end

      if (w_end) begin
        sdc_we    <= 1'b0;
        sdc_rd    <= 1'b0;
        r_host_rd <= 1'b0;
        if (!ready) begin
          r_init_cnt <= r_init_cnt - ICW'(1);
          if (r_init_cnt == ICW'(1)) ready <= 1'b1;
        end
      end
    end
  end

endmodule
